ddr_port_arbiter: RTL and testbench

//  Shares one DDR3 user command port between the packed-gray write stream (wr_en/wr_addr/wr_data/page_sel

---
 rtl/ddr_port_arbiter_if.sv | 34 +++
 rtl/ddr_port_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_port_arbiter_if.sv
// DDR3 user command/read-return bundle between ddr_port_arbiter (master)
// and the memory controller user interface (slave).
interface ddr_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 48
);
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic          mem_cmd_we;
    logic [AW-1:0] mem_cmd_addr;
    logic [DW-1:0] mem_cmd_wdata;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;

    modport master (
        output mem_cmd_valid,
        output mem_cmd_we,
        output mem_cmd_addr,
        output mem_cmd_wdata,
        input  mem_cmd_ready,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_cmd_valid,
        input  mem_cmd_we,
        input  mem_cmd_addr,
        input  mem_cmd_wdata,
        output mem_cmd_ready,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR3 user command port between the buffered gray-pixel write
// stream and the backlight block reader, with ping-pong page mapping for reads.
module ddr_port_arbiter #(
    parameter int AW            = 16,
    parameter int DW            = 48,
    parameter int WFIFO_DEPTH   = 4,
    parameter int WR_URGENT     = 3,
    parameter int PAGE_ONE_BASE = 1,
    parameter int PAGE_TWO_BASE = 11449
) (
    input  logic               i_pix_clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    input  logic               page_sel,
    input  logic               rd_req,
    input  logic [AW-1:0]      rd_offset,
    output logic               rd_ack,
    output logic               rd_valid,
    output logic [DW-1:0]      rd_data,
    output logic               rd_page,
    output logic               wr_overflow,
    ddr_port_arbiter_if.master mem
);

    localparam int PW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(WFIFO_DEPTH);
    localparam logic [CW-1:0] URGENT_CNT = CW'(WR_URGENT);
    localparam logic [AW-1:0] PAGE0_ADDR = AW'(PAGE_ONE_BASE);
    localparam logic [AW-1:0] PAGE1_ADDR = AW'(PAGE_TWO_BASE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMD  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [WFIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;

    logic          cmd_valid_q, cmd_we_q;
    logic [AW-1:0] cmd_addr_q;
    logic [DW-1:0] cmd_wdata_q;
    logic          last_wr_q, rd_out_q, rd_ack_q, rd_valid_q, ovf_q;
    logic [DW-1:0] rd_data_q;
    logic          page_sel_q, swap_pend_q, rd_page_q;

    logic          full_s, push_s, drop_s, wr_elig_s, rd_elig_s;
    logic          grant_wr_s, grant_rd_s, hs_s, pop_s, rd_hs_s, swap_apply_s;
    logic          rd_ret_s, page_chg_s;
    logic [AW-1:0] rd_addr_s;

    // A push into a full FIFO still lands when the head is leaving on the same edge.
    assign full_s     = (count_q == FULL_CNT);
    assign push_s     = wr_en & (~full_s | pop_s);
    assign drop_s     = wr_en & full_s & ~pop_s;
    assign wr_elig_s  = (count_q != {CW{1'b0}});
    assign rd_elig_s  = rd_req & ~rd_out_q & ~rd_ack_q & ~swap_pend_q;
    assign rd_ret_s   = mem.mem_rd_valid & rd_out_q;
    assign page_chg_s = page_sel ^ page_sel_q;
    assign rd_addr_s  = (rd_page_q ? PAGE1_ADDR : PAGE0_ADDR) + rd_offset;

    // Present-state register for the command FSM.
    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a granted command is held until the controller takes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_wr_s || grant_rd_s) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CMD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, handshake and page-swap decisions taken from registered state only.
    always_comb begin
        grant_wr_s   = 1'b0;
        grant_rd_s   = 1'b0;
        hs_s         = 1'b0;
        pop_s        = 1'b0;
        rd_hs_s      = 1'b0;
        swap_apply_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q >= URGENT_CNT) begin
                    grant_wr_s = 1'b1;
                end else if (wr_elig_s && rd_elig_s) begin
                    grant_rd_s = last_wr_q;
                    grant_wr_s = ~last_wr_q;
                end else if (wr_elig_s) begin
                    grant_wr_s = 1'b1;
                end else if (rd_elig_s) begin
                    grant_rd_s = 1'b1;
                end else begin
                    grant_wr_s = 1'b0;
                    grant_rd_s = 1'b0;
                end
                // rd_elig_s already excludes swap_pend, so a swap never coincides with a read grant.
                if (swap_pend_q && !rd_out_q) begin
                    swap_apply_s = 1'b1;
                end else begin
                    swap_apply_s = 1'b0;
                end
            end
            ST_CMD: begin
                hs_s    = cmd_valid_q & mem.mem_cmd_ready;
                pop_s   = hs_s & cmd_we_q;
                rd_hs_s = hs_s & ~cmd_we_q;
            end
            default: begin
                hs_s = 1'b0;
            end
        endcase
    end

    // Write FIFO occupancy follows push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Write FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WFIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= {AW{1'b0}};
                fifo_data_q[i] <= {DW{1'b0}};
            end
            wptr_q  <= {PW{1'b0}};
            rptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_addr_q[wptr_q] <= wr_addr;
                fifo_data_q[wptr_q] <= wr_data;
                wptr_q              <= wptr_q + PW'(1);
            end
            if (pop_s) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_d;
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Command register, read tracking and ping-pong page bookkeeping.
    always_ff @(posedge i_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= {AW{1'b0}};
            cmd_wdata_q <= {DW{1'b0}};
            last_wr_q   <= 1'b0;
            rd_out_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= {DW{1'b0}};
            page_sel_q  <= 1'b0;
            swap_pend_q <= 1'b0;
            rd_page_q   <= 1'b0;
        end else begin
            if (grant_wr_s) begin
                cmd_valid_q <= 1'b1;
                cmd_we_q    <= 1'b1;
                cmd_addr_q  <= fifo_addr_q[rptr_q];
                cmd_wdata_q <= fifo_data_q[rptr_q];
                last_wr_q   <= 1'b1;
            end else if (grant_rd_s) begin
                cmd_valid_q <= 1'b1;
                cmd_we_q    <= 1'b0;
                cmd_addr_q  <= rd_addr_s;
                cmd_wdata_q <= {DW{1'b0}};
                last_wr_q   <= 1'b0;
            end else if (hs_s) begin
                cmd_valid_q <= 1'b0;
            end
            rd_ack_q <= rd_hs_s;
            if (rd_hs_s) begin
                rd_out_q <= 1'b1;
            end else if (rd_ret_s) begin
                rd_out_q <= 1'b0;
            end
            rd_valid_q <= rd_ret_s;
            if (rd_ret_s) begin
                rd_data_q <= mem.mem_rd_data;
            end
            page_sel_q <= page_sel;
            if (page_chg_s) begin
                swap_pend_q <= 1'b1;
            end else if (swap_apply_s) begin
                swap_pend_q <= 1'b0;
            end
            // The reader addresses the page the packer is not writing.
            if (swap_apply_s) begin
                rd_page_q <= ~page_sel_q;
            end
        end
    end

    assign mem.mem_cmd_valid = cmd_valid_q;
    assign mem.mem_cmd_we    = cmd_we_q;
    assign mem.mem_cmd_addr  = cmd_addr_q;
    assign mem.mem_cmd_wdata = cmd_wdata_q;
    assign rd_ack            = rd_ack_q;
    assign rd_valid          = rd_valid_q;
    assign rd_data           = rd_data_q;
    assign rd_page           = rd_page_q;
    assign wr_overflow       = ovf_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: write path, FIFO overflow, read mapping,
// arbitration order, page swap timing and asynchronous reset.
module tb_ddr_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 48;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          page_sel;
    logic          rd_req;
    logic [AW-1:0] rd_offset;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_page;
    logic          wr_overflow;

    int            n_total;
    int            n_bad;
    int            n_rec;
    int            n_rdv;
    logic          rec_we   [8];
    logic [AW-1:0] rec_addr [8];
    logic [DW-1:0] rec_data [8];

    ddr_port_arbiter_if #(.AW(AW), .DW(DW)) mif ();

    ddr_port_arbiter #(
        .AW(AW), .DW(DW), .WFIFO_DEPTH(4), .WR_URGENT(3),
        .PAGE_ONE_BASE(1), .PAGE_TWO_BASE(11449)
    ) dut (
        .i_pix_clk   (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .page_sel    (page_sel),
        .rd_req      (rd_req),
        .rd_offset   (rd_offset),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_page     (rd_page),
        .wr_overflow (wr_overflow),
        .mem         (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (mif.mem_cmd_valid) break;
            tick();
        end
        check_val(tag, 64'(mif.mem_cmd_valid), 64'h1);
    endtask

    // Memory model: records accepted commands, returns read data one cycle after acceptance.
    task automatic run_mem(input int ncyc, input int stop_rd_after);
        logic ret_pend;
        ret_pend = 1'b0;
        n_rec    = 0;
        n_rdv    = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (rd_valid) n_rdv++;
            mif.mem_rd_valid = ret_pend;
            mif.mem_rd_data  = 48'h0000_CAFE_0000 + 48'(c);
            ret_pend         = 1'b0;
            if (mif.mem_cmd_valid && mif.mem_cmd_ready) begin
                if (n_rec < 8) begin
                    rec_we[n_rec]   = mif.mem_cmd_we;
                    rec_addr[n_rec] = mif.mem_cmd_addr;
                    rec_data[n_rec] = mif.mem_cmd_wdata;
                end
                n_rec++;
                if (!mif.mem_cmd_we) ret_pend = 1'b1;
                if (n_rec >= stop_rd_after) rd_req = 1'b0;
            end
            tick();
        end
        mif.mem_rd_valid = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 16'h0;
        wr_data = 48'h0;
        page_sel  = 1'b0;
        rd_req    = 1'b0;
        rd_offset = 16'h0;
        mif.mem_cmd_ready = 1'b0;
        mif.mem_rd_valid  = 1'b0;
        mif.mem_rd_data   = 48'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(mif.mem_cmd_valid), 64'h0);
        check_val("rst_addr",  64'(mif.mem_cmd_addr),  64'h0);
        check_val("rst_page",  64'(rd_page),           64'h0);
        check_val("rst_ovf",   64'(wr_overflow),       64'h0);
        check_val("rst_rdack", 64'(rd_ack),            64'h0);
        rst_n = 1'b1;
        tick();

        // Single write, controller always ready
        mif.mem_cmd_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 16'd5; wr_data = 48'h0102_0304_0506;
        tick();
        wr_en = 1'b0;
        check_val("t1_early", 64'(mif.mem_cmd_valid), 64'h0);
        tick();
        check_val("t1_valid", 64'(mif.mem_cmd_valid), 64'h1);
        check_val("t1_we",    64'(mif.mem_cmd_we),    64'h1);
        check_val("t1_addr",  64'(mif.mem_cmd_addr),  64'h5);
        check_val("t1_data",  64'(mif.mem_cmd_wdata), 64'h0102_0304_0506);
        tick();
        check_val("t1_drop",  64'(mif.mem_cmd_valid), 64'h0);
        tick();
        check_val("t1_empty", 64'(mif.mem_cmd_valid), 64'h0);

        // Five writes against a stalled controller: fifth is dropped
        mif.mem_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 16'h100 + 16'(i); wr_data = 48'h0000_AA00_0000 + 48'(i);
            tick();
            if (i == 3) check_val("t2_ovf_full", 64'(wr_overflow), 64'h0);
        end
        wr_en = 1'b0;
        check_val("t2_ovf",   64'(wr_overflow),       64'h1);
        check_val("t2_hold",  64'(mif.mem_cmd_addr),  64'h100);
        mif.mem_cmd_ready = 1'b1;
        run_mem(20, 99);
        check_val("t2_ncmd", 64'(n_rec), 64'h4);
        for (int i = 0; i < 4; i++) begin
            check_val("t2_order", 64'(rec_addr[i]), 64'h100 + 64'(i));
        end
        check_val("t2_data0", 64'(rec_data[0]), 64'h0000_AA00_0000);
        check_val("t2_data3", 64'(rec_data[3]), 64'h0000_AA00_0003);

        // Page toggle then read at offset 10 from page 0
        page_sel = 1'b1;
        repeat (3) tick();
        check_val("t3_page", 64'(rd_page), 64'h0);
        rd_req = 1'b1; rd_offset = 16'd10;
        wait_cmd("t3_wait", 10);
        check_val("t3_we",    64'(mif.mem_cmd_we),    64'h0);
        check_val("t3_addr",  64'(mif.mem_cmd_addr),  64'd11);
        check_val("t3_wdata", 64'(mif.mem_cmd_wdata), 64'h0);
        tick();
        check_val("t3_ack",   64'(rd_ack), 64'h1);
        rd_req = 1'b0;
        tick();
        check_val("t3_ack_pulse", 64'(rd_ack), 64'h0);
        mif.mem_rd_valid = 1'b1; mif.mem_rd_data = 48'hA5A5_1234_5678;
        tick();
        mif.mem_rd_valid = 1'b0;
        check_val("t3_rdv",  64'(rd_valid), 64'h1);
        check_val("t3_rdd",  64'(rd_data),  64'hA5A5_1234_5678);
        tick();
        check_val("t3_rdv_pulse", 64'(rd_valid), 64'h0);

        // Read and writes compete: R, W, R, W
        mif.mem_cmd_ready = 1'b0;
        rd_req = 1'b1; rd_offset = 16'd3;
        wr_en = 1'b1; wr_addr = 16'h200; wr_data = 48'h0000_0000_0200;
        tick();
        wr_addr = 16'h201; wr_data = 48'h0000_0000_0201;
        tick();
        wr_en = 1'b0;
        mif.mem_cmd_ready = 1'b1;
        run_mem(16, 4);
        check_val("t4_ncmd", 64'(n_rec), 64'h4);
        check_val("t4_g0", 64'(rec_we[0]), 64'h0);
        check_val("t4_g1", 64'(rec_we[1]), 64'h1);
        check_val("t4_g2", 64'(rec_we[2]), 64'h0);
        check_val("t4_g3", 64'(rec_we[3]), 64'h1);
        check_val("t4_raddr", 64'(rec_addr[2]), 64'd4);
        check_val("t4_waddr", 64'(rec_addr[3]), 64'h201);
        check_val("t4_nrdv", 64'(n_rdv), 64'h2);

        // FIFO at the urgent level wins even right after a write grant
        mif.mem_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 16'h300 + 16'(i); wr_data = 48'h0000_0000_0300 + 48'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_req = 1'b1; rd_offset = 16'd3;
        mif.mem_cmd_ready = 1'b1;
        run_mem(24, 3);
        check_val("t4u_ncmd", 64'(n_rec), 64'h5);
        check_val("t4u_g0", 64'(rec_we[0]), 64'h1);
        check_val("t4u_g1", 64'(rec_we[1]), 64'h1);
        check_val("t4u_a1", 64'(rec_addr[1]), 64'h301);
        check_val("t4u_g2", 64'(rec_we[2]), 64'h0);

        // Page toggle while a read is outstanding
        rd_req = 1'b1; rd_offset = 16'd7;
        wait_cmd("t5_wait", 10);
        check_val("t5_addr", 64'(mif.mem_cmd_addr), 64'd8);
        tick();
        check_val("t5_ack", 64'(rd_ack), 64'h1);
        rd_req = 1'b0;
        page_sel = 1'b0;
        repeat (4) tick();
        check_val("t5_hold", 64'(rd_page), 64'h0);
        mif.mem_rd_valid = 1'b1; mif.mem_rd_data = 48'h0000_BEEF_0005;
        tick();
        mif.mem_rd_valid = 1'b0;
        check_val("t5_rdv",   64'(rd_valid), 64'h1);
        check_val("t5_hold2", 64'(rd_page),  64'h0);
        tick();
        check_val("t5_swap", 64'(rd_page), 64'h1);
        rd_req = 1'b1; rd_offset = 16'd7;
        wait_cmd("t5_wait2", 10);
        check_val("t5_addr2", 64'(mif.mem_cmd_addr), 64'd11456);
        tick();
        rd_req = 1'b0;
        mif.mem_rd_valid = 1'b1;
        tick();
        mif.mem_rd_valid = 1'b0;
        tick();

        // Reset with a write held in CMD and a read outstanding
        rd_req = 1'b1; rd_offset = 16'd1;
        wait_cmd("t6_wait", 10);
        check_val("t6_addr", 64'(mif.mem_cmd_addr), 64'd11450);
        tick();
        rd_req = 1'b0;
        mif.mem_cmd_ready = 1'b0;
        wr_en = 1'b1; wr_addr = 16'h55; wr_data = 48'h0000_0000_0055;
        tick();
        wr_en = 1'b0;
        tick();
        check_val("t6_cmdwe", 64'(mif.mem_cmd_we), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_valid", 64'(mif.mem_cmd_valid), 64'h0);
        check_val("t6_we",    64'(mif.mem_cmd_we),    64'h0);
        check_val("t6_addr0", 64'(mif.mem_cmd_addr),  64'h0);
        check_val("t6_wdata", 64'(mif.mem_cmd_wdata), 64'h0);
        check_val("t6_page",  64'(rd_page),           64'h0);
        check_val("t6_ovf",   64'(wr_overflow),       64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        mif.mem_cmd_ready = 1'b1;
        mif.mem_rd_valid = 1'b1; mif.mem_rd_data = 48'h0000_DEAD_0006;
        tick();
        mif.mem_rd_valid = 1'b0;
        check_val("t6_rdv", 64'(rd_valid), 64'h0);
        tick();
        check_val("t6_nocmd", 64'(mif.mem_cmd_valid), 64'h0);
        tick();
        check_val("t6_nocmd2", 64'(mif.mem_cmd_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
